// File: rtl/cache_access_model.sv
// Tag-only set-associative cache model with hit/miss/traffic counters.
// Define CACHE_SAT_COUNT_EN to make the counters saturate instead of wrap.
module cache_access_model #(
    parameter int CACHE_BYTES = 1024,
    parameter int ASSOC       = 2,
    parameter int BLOCK_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_policy,
    input  logic        replace_policy,
    input  logic [1:0]  inclusion_policy,
    input  logic [47:0] cache_addr,
    input  logic [7:0]  cache_op,
    output logic [11:0] num_reads,
    output logic [11:0] num_writes,
    output logic [11:0] num_misses,
    output logic [11:0] num_hits,
    output logic [31:0] curr_tag
);
    localparam int SETS = CACHE_BYTES / (BLOCK_BYTES * ASSOC);
    localparam int OFF  = $clog2(BLOCK_BYTES);
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = 48 - OFF - IDX;
    localparam int WW   = (ASSOC > 1) ? $clog2(ASSOC) : 1;

    localparam logic [7:0] OP_RD = 8'h52;
    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [WW-1:0] OLDEST = WW'(ASSOC - 1);

    logic [TAG-1:0] tags  [SETS][ASSOC];
    logic           valid [SETS][ASSOC];
    logic           dirty [SETS][ASSOC];
    logic [WW-1:0]  age   [SETS][ASSOC];

    logic [55:0]    last_req;
    logic [IDX-1:0] set_idx;
    logic [TAG-1:0] req_tag;
    logic           is_rd;
    logic           is_wr;
    logic           accept;

    logic           hit;
    logic [WW-1:0]  hit_way;
    logic           has_inv;
    logic [WW-1:0]  inv_way;
    logic [WW-1:0]  old_way;
    logic [WW-1:0]  max_age;
    logic [WW-1:0]  victim;
    logic           fill;
    logic           touch;
    logic [WW-1:0]  touch_way;
    logic [WW-1:0]  touch_age;

    logic unused_bits;
    assign unused_bits = ^{inclusion_policy, cache_addr[OFF-1:0]};

    assign set_idx = cache_addr[OFF+IDX-1:OFF];
    assign req_tag = cache_addr[47:OFF+IDX];
    assign is_rd   = (cache_op == OP_RD);
    assign is_wr   = (cache_op == OP_WR);
    assign accept  = (is_rd || is_wr) && ({cache_addr, cache_op} != last_req);

    function automatic logic [11:0] bump(input logic [11:0] v);
`ifdef CACHE_SAT_COUNT_EN
        return (v == 12'hFFF) ? v : v + 12'd1;
`else
        return v + 12'd1;
`endif
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        old_way = '0;
        max_age = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (valid[set_idx][w] && tags[set_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (age[set_idx][w] >= max_age) begin
                max_age = age[set_idx][w];
                old_way = WW'(w);
            end
        end
        // Scan downward so the lowest-numbered invalid way wins
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (!valid[set_idx][w]) begin
                has_inv = 1'b1;
                inv_way = WW'(w);
            end
        end
    end

    assign victim    = has_inv ? inv_way : old_way;
    assign fill      = accept && !hit && !(is_wr && write_policy);
    assign touch     = fill || (accept && hit && !replace_policy);
    assign touch_way = hit ? hit_way : victim;
    // An empty way ranks as oldest so filling it shifts every live way down
    assign touch_age = valid[set_idx][touch_way] ? age[set_idx][touch_way]
                                                 : OLDEST;

    always_ff @(posedge clk) begin
        if (fill) tags[set_idx][victim] <= req_tag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    age[s][w]   <= '0;
                end
            end
            last_req   <= '0;
            num_reads  <= '0;
            num_writes <= '0;
            num_misses <= '0;
            num_hits   <= '0;
            curr_tag   <= '0;
        end else begin
            last_req <= {cache_addr, cache_op};
            if (accept) begin
                curr_tag <= 32'(req_tag);
                if (hit) begin
                    num_hits <= bump(num_hits);
                    if (is_wr && !write_policy)
                        dirty[set_idx][hit_way] <= 1'b1;
                    if (is_wr && write_policy)
                        num_writes <= bump(num_writes);
                end else if (is_wr && write_policy) begin
                    num_misses <= bump(num_misses);
                    num_writes <= bump(num_writes);
                end else begin
                    num_misses <= bump(num_misses);
                    num_reads  <= bump(num_reads);
                    if (valid[set_idx][victim] && dirty[set_idx][victim])
                        num_writes <= bump(num_writes);
                    valid[set_idx][victim] <= 1'b1;
                    dirty[set_idx][victim] <= is_wr;
                end
            end
            if (touch) begin
                for (int w = 0; w < ASSOC; w++) begin
                    if (WW'(w) == touch_way)
                        age[set_idx][w] <= '0;
                    else if (valid[set_idx][w] && age[set_idx][w] < touch_age)
                        age[set_idx][w] <= age[set_idx][w] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cache_access_model.sv
// Directed self-checking bench for cache_access_model.
// Expected values are hand-computed for 1 KiB, 2-way, 64 B lines.
module tb_cache_access_model;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write_policy = 1'b0;
    logic        replace_policy = 1'b0;
    logic [1:0]  inclusion_policy = 2'b00;
    logic [47:0] cache_addr = '0;
    logic [7:0]  cache_op = 8'h00;
    logic [11:0] num_reads, num_writes, num_misses, num_hits;
    logic [31:0] curr_tag;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] R = 8'h52;
    localparam logic [7:0] W = 8'h57;

    cache_access_model dut (
        .clk(clk),
        .reset(reset),
        .write_policy(write_policy),
        .replace_policy(replace_policy),
        .inclusion_policy(inclusion_policy),
        .cache_addr(cache_addr),
        .cache_op(cache_op),
        .num_reads(num_reads),
        .num_writes(num_writes),
        .num_misses(num_misses),
        .num_hits(num_hits),
        .curr_tag(curr_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        cache_op = 8'h00;
        cache_addr = '0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One-cycle request followed by a no-op separator
    task automatic do_req(input logic [7:0] op, input logic [47:0] a);
        @(negedge clk);
        cache_op = op;
        cache_addr = a;
        @(negedge clk);
        cache_op = 8'h00;
    endtask

    task automatic lru_seq();
        do_req(R, 48'h000);
        do_req(R, 48'h200);
        do_req(R, 48'h000);
        do_req(R, 48'h400);
        do_req(R, 48'h000);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_reads", 32'(num_reads), 0);
        chk("rst_writes", 32'(num_writes), 0);
        chk("rst_misses", 32'(num_misses), 0);
        chk("rst_hits", 32'(num_hits), 0);
        chk("rst_tag", curr_tag, 0);
        reset = 1'b1;

        do_req(R, 48'h0000006324d8);
        chk("t1_misses", 32'(num_misses), 1);
        chk("t1_reads", 32'(num_reads), 1);
        chk("t1_hits", 32'(num_hits), 0);
        chk("t1_tag", curr_tag, 32'h3192);
        do_req(R, 48'h0000006324c0);
        chk("t1b_hits", 32'(num_hits), 1);
        chk("t1b_misses", 32'(num_misses), 1);

        do_reset();
        replace_policy = 1'b0;
        lru_seq();
        chk("lru_hits", 32'(num_hits), 2);
        chk("lru_misses", 32'(num_misses), 3);

        do_reset();
        replace_policy = 1'b1;
        lru_seq();
        chk("fifo_hits", 32'(num_hits), 1);
        chk("fifo_misses", 32'(num_misses), 4);

        do_reset();
        replace_policy = 1'b0;
        write_policy = 1'b0;
        do_req(W, 48'h000);
        do_req(R, 48'h200);
        do_req(R, 48'h400);
        chk("wb_writes", 32'(num_writes), 1);
        chk("wb_reads", 32'(num_reads), 3);
        chk("wb_misses", 32'(num_misses), 3);

        do_reset();
        write_policy = 1'b1;
        do_req(W, 48'h000);
        do_req(R, 48'h000);
        chk("wt_misses", 32'(num_misses), 2);
        chk("wt_writes", 32'(num_writes), 1);
        chk("wt_reads", 32'(num_reads), 1);
        do_req(W, 48'h000);
        chk("wt_hits", 32'(num_hits), 1);
        chk("wt_writes2", 32'(num_writes), 2);

        do_reset();
        write_policy = 1'b0;
        @(negedge clk);
        cache_op = R;
        cache_addr = 48'h1000;
        repeat (5) @(negedge clk);
        chk("hold_misses", 32'(num_misses), 1);
        chk("hold_reads", 32'(num_reads), 1);
        chk("hold_hits", 32'(num_hits), 0);
        chk("hold_tag", curr_tag, 32'h8);
        cache_op = 8'h00;
        @(negedge clk);
        cache_op = R;
        @(negedge clk);
        chk("noop_hits", 32'(num_hits), 1);
        chk("noop_misses", 32'(num_misses), 1);

        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_hits", 32'(num_hits), 0);
        chk("async_misses", 32'(num_misses), 0);
        chk("async_reads", 32'(num_reads), 0);
        chk("async_tag", curr_tag, 0);
        @(negedge clk);
        cache_op = 8'h00;
        reset = 1'b1;
        do_req(R, 48'h1000);
        chk("post_misses", 32'(num_misses), 1);
        chk("post_hits", 32'(num_hits), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
